// File: rtl/i2c_master_byte.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_byte
// Purpose  : Single-byte I2C master (START, addr+R/W, ACK, one data byte,
//            ACK/NACK, STOP) sequenced from gen_clk's SCL edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_byte #(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              scl_posedge,
    input  logic              scl_negedge,
    input  logic              start_req,
    input  logic              rw,
    input  logic [6:0]        dev_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_en,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [3:0] c_IDLE       = 4'd0;
    localparam logic [3:0] c_WAIT_START = 4'd1;
    localparam logic [3:0] c_ADDR       = 4'd2;
    localparam logic [3:0] c_ADDR_ACK   = 4'd3;
    localparam logic [3:0] c_WDATA      = 4'd4;
    localparam logic [3:0] c_WACK       = 4'd5;
    localparam logic [3:0] c_RDATA      = 4'd6;
    localparam logic [3:0] c_MACK       = 4'd7;
    localparam logic [3:0] c_PRE_STOP   = 4'd8;
    localparam logic [3:0] c_STOP       = 4'd9;
    localparam logic [3:0] c_DONE       = 4'd10;

    logic [3:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_sda_oe;
    logic              r_scl_en;
    logic              r_busy;
    logic              r_done;
    logic              r_ack_err;

    logic              w_pos;
    logic              w_neg;

    // Rising strobe wins if gen_clk ever asserts both in one cycle.
    assign w_pos = scl_posedge;
    assign w_neg = scl_negedge & ~scl_posedge;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_sda_oe  <= 1'b0;
            r_scl_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_req) begin
                        r_shift   <= {dev_addr, rw};
                        r_wdata   <= wdata;
                        r_ack_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_WAIT_START;
                    end
                end
                c_WAIT_START: begin
                    // SCL is released high here, so pulling SDA forms START.
                    if (w_pos) begin
                        r_sda_oe  <= 1'b1;
                        r_scl_en  <= 1'b1;
                        r_bit_cnt <= 3'd7;
                        r_state   <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (w_pos) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= c_ADDR_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end else if (w_neg) begin
                        r_sda_oe <= ~r_shift[r_bit_cnt];
                    end
                end
                c_ADDR_ACK: begin
                    if (w_pos) begin
                        r_bit_cnt <= 3'd7;
                        if (sda_in) begin
                            r_ack_err <= 1'b1;
                            r_state   <= c_PRE_STOP;
                        end else if (r_shift[0]) begin
                            r_state <= c_RDATA;
                        end else begin
                            r_state <= c_WDATA;
                        end
                    end else if (w_neg) begin
                        r_sda_oe <= 1'b0;
                    end
                end
                c_WDATA: begin
                    if (w_pos) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= c_WACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end else if (w_neg) begin
                        r_sda_oe <= ~r_wdata[r_bit_cnt];
                    end
                end
                c_WACK: begin
                    if (w_pos) begin
                        if (sda_in) begin
                            r_ack_err <= 1'b1;
                        end
                        r_state <= c_PRE_STOP;
                    end else if (w_neg) begin
                        r_sda_oe <= 1'b0;
                    end
                end
                c_RDATA: begin
                    if (w_pos) begin
                        r_rdata[r_bit_cnt] <= sda_in;
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= c_MACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                    end else if (w_neg) begin
                        r_sda_oe <= 1'b0;
                    end
                end
                c_MACK: begin
                    // Single-byte read always ends with a master NACK.
                    if (w_pos) begin
                        r_state <= c_PRE_STOP;
                    end else if (w_neg) begin
                        r_sda_oe <= 1'b0;
                    end
                end
                c_PRE_STOP: begin
                    if (w_pos) begin
                        r_state <= c_STOP;
                    end else if (w_neg) begin
                        r_sda_oe <= 1'b1;
                    end
                end
                c_STOP: begin
                    // SCL is high: releasing SDA forms STOP, then park SCL.
                    r_sda_oe <= 1'b0;
                    r_scl_en <= 1'b0;
                    r_state  <= c_DONE;
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign sda_oe  = r_sda_oe;
    assign scl_en  = r_scl_en;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_byte
// Purpose  : Bench for i2c_master_byte with a bus-level slave/monitor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_byte;

    localparam int c_TXN_LIMIT = 240;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rbyte;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       start_req;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] wdata;
    logic       sda_oe;
    logic       scl_en;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       scl_posedge;
    logic       scl_negedge;
    logic       sda_in;

    logic [2:0] cnt = 3'd0;
    int         cyc = 0;
    logic       w_scl;
    logic       w_sda;

    // Slave/monitor state (written only by the monitor process)
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        slave_pull = 1'b0;
    logic        rw_seen = 1'b0;
    int          n_start = 0;
    int          n_stop = 0;
    int          nbits = 0;
    int          start_cyc = 0;
    logic [31:0] mbits = '0;

    // Slave configuration (written only by the stimulus process)
    logic       mon_clear;
    logic       cfg_ack_addr;
    logic       cfg_ack_data;
    logic [7:0] cfg_rbyte;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [5];

    always #5 clk_in = ~clk_in;

    // gen_clk stand-in: 8-cycle SCL period, high for phases 0..3
    always @(posedge clk_in) begin
        cnt <= cnt + 3'd1;
        cyc <= cyc + 1;
    end
    assign scl_posedge = (cnt == 3'd0);
    assign scl_negedge = (cnt == 3'd4);
    assign w_scl       = scl_en ? (cnt < 3'd4) : 1'b1;
    assign w_sda       = ~sda_oe & ~slave_pull;
    assign sda_in      = w_sda;

    i2c_master_byte #(.DATA_W(8)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .scl_posedge (scl_posedge),
        .scl_negedge (scl_negedge),
        .start_req   (start_req),
        .rw          (rw),
        .dev_addr    (dev_addr),
        .wdata       (wdata),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .scl_en      (scl_en),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .rdata       (rdata)
    );

    // What the slave puts on SDA for bit number k+1, given k bits clocked so far
    function automatic logic slave_drive(input int k);
        if (k == 8)             return cfg_ack_addr;
        if (k >= 9 && k <= 16)  return rw_seen && cfg_ack_addr && !cfg_rbyte[16 - k];
        if (k == 17)            return cfg_ack_data && !rw_seen;
        return 1'b0;
    endfunction

    always @(negedge clk_in) begin
        prev_scl <= w_scl;
        prev_sda <= w_sda;
        if (mon_clear) begin
            n_start    <= 0;
            n_stop     <= 0;
            nbits      <= 0;
            mbits      <= '0;
            slave_pull <= 1'b0;
            rw_seen    <= 1'b0;
        end else if (prev_scl && w_scl && prev_sda && !w_sda) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            nbits     <= 0;
            mbits     <= '0;
        end else if (prev_scl && w_scl && !prev_sda && w_sda) begin
            n_stop <= n_stop + 1;
        end else if (!prev_scl && w_scl) begin
            mbits <= {mbits[30:0], ~sda_oe};
            nbits <= nbits + 1;
            if (nbits == 7) rw_seen <= w_sda;
        end else if (prev_scl && !w_scl) begin
            slave_pull <= slave_drive(nbits);
        end
    end

    // Reference: the level the master itself puts on SDA at each SCL rise
    function automatic void ref_bits(input vec_t v, output logic [31:0] bits, output int n);
        logic [7:0] a;
        a    = {v.addr, v.rw};
        bits = '0;
        n    = 0;
        for (int i = 7; i >= 0; i--) begin bits = {bits[30:0], a[i]}; n++; end
        bits = {bits[30:0], 1'b1}; n++;
        if (v.ack_addr) begin
            for (int i = 7; i >= 0; i--) begin
                bits = {bits[30:0], (v.rw ? 1'b1 : v.wdata[i])}; n++;
            end
            bits = {bits[30:0], 1'b1}; n++;
        end
        bits = {bits[30:0], 1'b0}; n++;
    endfunction

    function automatic logic ref_err(input vec_t v);
        return !v.ack_addr || (!v.rw && !v.ack_data);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+#1; issues the request in the current cycle.
    task automatic run_txn(input vec_t v, input bit poke, input bit b2b);
        logic [31:0] eb;
        int          en;
        int          acc;
        int          gc;
        int          ndone;
        bit          got;
        ref_bits(v, eb, en);
        cfg_ack_addr = v.ack_addr;
        cfg_ack_data = v.ack_data;
        cfg_rbyte    = v.rbyte;
        mon_clear    = 1'b1;
        rw           = v.rw;
        dev_addr     = v.addr;
        wdata        = v.wdata;
        start_req    = 1'b1;
        acc          = cyc;
        @(posedge clk_in); #1;
        mon_clear = 1'b0;
        start_req = 1'b0;
        rw        = ~v.rw;
        dev_addr  = ~v.addr;
        wdata     = ~v.wdata;
        check("busy_after_accept", busy, 1);
        check("ack_err_cleared", ack_err, 0);
        got   = 0;
        gc    = 0;
        ndone = 0;
        for (int c = 0; c < c_TXN_LIMIT; c++) begin
            if (poke && c == 40) begin start_req = 1'b1; dev_addr = 7'h11; rw = 1'b1; end
            if (poke && c == 44) start_req = 1'b0;
            @(posedge clk_in); #1;
            if (done) begin
                ndone++;
                if (!got) begin
                    got = 1;
                    gc  = c;
                    check("master_bits", mbits, eb);
                    check("bit_count", nbits, en);
                    check("start_count", n_start, 1);
                    check("stop_count", n_stop, 1);
                    check("start_latency", ((start_cyc - acc) >= 2) && ((start_cyc - acc) <= 10), 1);
                    check("ack_err", ack_err, v.exp_err);
                    check("busy_at_done", busy, 0);
                    if (v.rw && v.ack_addr) check("rdata", rdata, v.exp_rdata);
                    if (b2b) break;
                end
            end
            if (got && c >= gc + 12) break;
        end
        check("done_seen", got, 1);
        if (got) check("done_pulses", ndone, 1);
    endtask

    initial begin
        vec_t v;
        bit   found;
        reset        = 1'b1;
        start_req    = 1'b0;
        rw           = 1'b0;
        dev_addr     = 7'h00;
        wdata        = 8'h00;
        mon_clear    = 1'b1;
        cfg_ack_addr = 1'b0;
        cfg_ack_data = 1'b0;
        cfg_rbyte    = 8'h00;

        //            rw    addr   wdata  ackA  ackD  rbyte  err   rdata
        tbl[0] = '{1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 7'h3F, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 7'h48, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C};
        tbl[3] = '{1'b0, 7'h2A, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[4] = '{1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81};

        repeat (4) @(posedge clk_in);
        #1;
        check("reset_state", {sda_oe, scl_en, busy, done, ack_err, rdata}, 0);
        reset = 1'b0;
        @(posedge clk_in); #1;

        for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0, 1'b0);

        // start_req with another address while busy must change nothing
        run_txn(tbl[0], 1'b1, 1'b0);

        // Reset in the middle of data bit 4 of a write
        cfg_ack_addr = 1'b1;
        cfg_ack_data = 1'b1;
        cfg_rbyte    = 8'h00;
        mon_clear    = 1'b1;
        rw           = 1'b0;
        dev_addr     = 7'h50;
        wdata        = 8'hA5;
        start_req    = 1'b1;
        @(posedge clk_in); #1;
        mon_clear = 1'b0;
        start_req = 1'b0;
        found     = 0;
        for (int c = 0; c < c_TXN_LIMIT; c++) begin
            @(posedge clk_in); #1;
            if (nbits == 12 && cnt == 3'd6) begin found = 1; break; end
        end
        check("reached_wdata_bit4", found, 1);
        check("pre_reset_drive", {sda_oe, scl_en, busy}, 3'b111);
        reset = 1'b1;
        @(posedge clk_in); #1;
        check("mid_txn_reset", {sda_oe, scl_en, busy, done}, 4'b0000);
        reset = 1'b0;
        @(posedge clk_in); #1;
        run_txn(tbl[0], 1'b0, 1'b0);

        // Back-to-back: NACK, new request on the done cycle, then again from idle
        run_txn(tbl[1], 1'b0, 1'b1);
        run_txn(tbl[0], 1'b0, 1'b0);
        run_txn(tbl[2], 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            v.rw        = 1'($urandom);
            v.addr      = 7'($urandom);
            v.wdata     = 8'($urandom);
            v.ack_addr  = ($urandom_range(0, 3) != 0);
            v.ack_data  = ($urandom_range(0, 3) != 0);
            v.rbyte     = 8'($urandom);
            v.exp_err   = ref_err(v);
            v.exp_rdata = v.rbyte;
            run_txn(v, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
